// File: rtl/stl_lut_arb.sv
// Round-robin arbiter in front of a small key/data lookup table. One requester
// is granted per IDLE cycle; its lookup result is held in RESP until accepted.
module stl_lut_arb #(
    parameter int NR_REQ      = 4,
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 4,
    parameter int DATA_LEN    = 8,
    parameter int HAS_DEFAULT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [$clog2(NR_KEY)-1:0]   cfg_idx,
    input  logic [KEY_LEN-1:0]          cfg_key,
    input  logic [DATA_LEN-1:0]         cfg_data,
    input  logic                        cfg_clr,
    input  logic [DATA_LEN-1:0]         default_out,
    input  logic [NR_REQ-1:0]           req_valid,
    input  logic [NR_REQ*KEY_LEN-1:0]   req_key,
    output logic [NR_REQ-1:0]           req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NR_REQ)-1:0]   rsp_id,
    output logic [DATA_LEN-1:0]         rsp_data,
    output logic                        rsp_hit
);

    localparam int ID_W = $clog2(NR_REQ);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t                r_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [NR_KEY-1:0]     r_valid;
    logic [KEY_LEN-1:0]    r_key  [NR_KEY];
    logic [DATA_LEN-1:0]   r_data [NR_KEY];
    logic                  r_rsp_valid;
    logic [ID_W-1:0]       r_rsp_id;
    logic [DATA_LEN-1:0]   r_rsp_data;
    logic                  r_rsp_hit;

    logic [NR_REQ-1:0]     w_req_rot;
    logic                  w_gnt_found;
    logic [ID_W-1:0]       w_gnt_id;
    logic [ID_W:0]         w_sum;
    logic [ID_W-1:0]       w_rr_next;
    logic [NR_REQ-1:0]     w_ready;
    logic [KEY_LEN-1:0]    w_gnt_key;
    logic                  w_hit;
    logic [DATA_LEN-1:0]   w_or_data;
    logic [DATA_LEN-1:0]   w_lkp_data;

    // Rotate requests so bit 0 is the requester at rr_ptr, then pick the lowest set bit.
    assign w_req_rot = NR_REQ'({req_valid, req_valid} >> r_rr_ptr);

    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        w_sum       = '0;
        for (int k = 0; k < NR_REQ; k++) begin
            if (!w_gnt_found && w_req_rot[k]) begin
                w_gnt_found = 1'b1;
                w_sum       = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
                if (w_sum >= (ID_W+1)'(NR_REQ))
                    w_sum = w_sum - (ID_W+1)'(NR_REQ);
                w_gnt_id = w_sum[ID_W-1:0];
            end
        end
    end

    assign w_rr_next = (w_gnt_id == ID_W'(NR_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NR_REQ; i++)
            w_ready[i] = (r_state == S_IDLE) && w_gnt_found && (w_gnt_id == ID_W'(i));
    end

    // Lookup sees the table as registered, so same-cycle cfg writes do not affect it.
    always_comb begin
        w_gnt_key = '0;
        for (int i = 0; i < NR_REQ; i++)
            if (w_gnt_id == ID_W'(i))
                w_gnt_key = req_key[i*KEY_LEN +: KEY_LEN];
        w_hit     = 1'b0;
        w_or_data = '0;
        for (int e = 0; e < NR_KEY; e++) begin
            if (r_valid[e] && (r_key[e] == w_gnt_key)) begin
                w_hit     = 1'b1;
                w_or_data = w_or_data | r_data[e];
            end
        end
        w_lkp_data = w_hit ? w_or_data : ((HAS_DEFAULT != 0) ? default_out : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst && cfg_we) begin
            r_key[cfg_idx]  <= cfg_key;
            r_data[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_valid     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_hit   <= 1'b0;
        end else begin
            // Clear first so a simultaneous write still lands as valid.
            if (cfg_clr)
                r_valid <= '0;
            if (cfg_we)
                r_valid[cfg_idx] <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_gnt_found) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= w_gnt_id;
                        r_rsp_data  <= w_lkp_data;
                        r_rsp_hit   <= w_hit;
                        r_rr_ptr    <= w_rr_next;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_hit   = r_rsp_hit;

endmodule

// File: tb/tb_stl_lut_arb.sv
// Bench for stl_lut_arb: vector table plus hand sequences, with a response
// scoreboard; a second instance with HAS_DEFAULT=0 shares the stimulus.
module tb_stl_lut_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [3:0]  cfg_key;
    logic [7:0]  cfg_data;
    logic        cfg_clr;
    logic [7:0]  default_out;
    logic [3:0]  req_valid;
    logic [15:0] req_key;
    logic        rsp_ready;

    logic [3:0]  req_ready,  req_ready_nd;
    logic        rsp_valid,  rsp_valid_nd;
    logic [1:0]  rsp_id,     rsp_id_nd;
    logic [7:0]  rsp_data,   rsp_data_nd;
    logic        rsp_hit,    rsp_hit_nd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stl_lut_arb u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
        .cfg_data(cfg_data), .cfg_clr(cfg_clr), .default_out(default_out),
        .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_hit(rsp_hit)
    );

    stl_lut_arb #(.HAS_DEFAULT(0)) u_dut_nd (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
        .cfg_data(cfg_data), .cfg_clr(cfg_clr), .default_out(default_out),
        .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready_nd),
        .rsp_valid(rsp_valid_nd), .rsp_ready(rsp_ready), .rsp_id(rsp_id_nd),
        .rsp_data(rsp_data_nd), .rsp_hit(rsp_hit_nd)
    );

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] keys;
        logic [7:0]  dflt;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_id;
        logic        exp_hit;
        logic [7:0]  exp_data;
        logic [7:0]  exp_data_nd;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic       hit;
        logic [7:0] data;
        logic [7:0] data_nd;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cfg(input logic clr, input logic we, input logic [1:0] idx,
                       input logic [3:0] key, input logic [7:0] data);
        @(negedge clk);
        cfg_clr = clr; cfg_we = we; cfg_idx = idx; cfg_key = key; cfg_data = data;
        @(negedge clk);
        cfg_clr = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic wait_rsp();
        bit   got;
        exp_t e;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty actual=response expected=none");
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id",      32'(rsp_id),       32'(e.id));
                    chk("rsp_data",    32'(rsp_data),     32'(e.data));
                    chk("rsp_hit",     32'(rsp_hit),      32'(e.hit));
                    chk("nd_valid",    32'(rsp_valid_nd), 32'(1));
                    chk("nd_data",     32'(rsp_data_nd),  32'(e.data_nd));
                    chk("nd_hit",      32'(rsp_hit_nd),   32'(e.hit));
                end
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL rsp_timeout actual=no_rsp_valid expected=rsp_valid");
        end
    endtask

    // Grant in one cycle, release requests, then default_out changes to prove it was sampled.
    task automatic apply(input vec_t v);
        @(negedge clk);
        req_valid = v.mask; req_key = v.keys; default_out = v.dflt; rsp_ready = 1'b1;
        #1;
        chk("req_ready", 32'(req_ready), 32'(v.exp_ready));
        sb.push_back('{v.exp_id, v.exp_hit, v.exp_data, v.exp_data_nd});
        @(negedge clk);
        req_valid = '0; default_out = 8'h00;
        wait_rsp();
    endtask

    initial begin
        vecs[0] = '{4'b0001, 16'h0007, 8'hEE, 4'b0001, 2'd0, 1'b1, 8'h3C, 8'h3C};
        vecs[1] = '{4'b0010, 16'h0030, 8'hEE, 4'b0010, 2'd1, 1'b1, 8'hA5, 8'hA5};
        vecs[2] = '{4'b0100, 16'h0900, 8'hEE, 4'b0100, 2'd2, 1'b0, 8'hEE, 8'h00};
        vecs[3] = '{4'b1000, 16'h5000, 8'h11, 4'b1000, 2'd3, 1'b1, 8'hFF, 8'hFF};
        vecs[4] = '{4'b1010, 16'h7030, 8'hEE, 4'b0010, 2'd1, 1'b1, 8'hA5, 8'hA5};
        vecs[5] = '{4'b1011, 16'h7012, 8'hEE, 4'b1000, 2'd3, 1'b1, 8'h3C, 8'h3C};
        vecs[6] = '{4'b0110, 16'h0400, 8'h5A, 4'b0010, 2'd1, 1'b0, 8'h5A, 8'h00};
        vecs[7] = '{4'b0011, 16'h0035, 8'hEE, 4'b0001, 2'd0, 1'b1, 8'hFF, 8'hFF};

        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_key = '0; cfg_data = '0; cfg_clr = 1'b0;
        default_out = '0; req_valid = '0; req_key = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_id",    32'(rsp_id),    32'(0));
        chk("rst_rsp_data",  32'(rsp_data),  32'(0));
        chk("rst_rsp_hit",   32'(rsp_hit),   32'(0));
        chk("rst_req_ready", 32'(req_ready), 32'(0));

        // All requesters held from reset: grants 0,1,2,3,0 on alternate cycles.
        rst = 1'b0; req_valid = 4'hF;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk("rr_ready", 32'(req_ready), 32'(1 << ((k / 2) % 4)));
                chk("rr_idle_valid", 32'(rsp_valid), 32'(0));
            end else begin
                chk("rr_ready_resp", 32'(req_ready), 32'(0));
                chk("rr_valid", 32'(rsp_valid), 32'(1));
                chk("rr_id", 32'(rsp_id), 32'((k / 2) % 4));
            end
            if (k == 9) req_valid = '0;
            @(negedge clk);
        end

        cfg(1'b0, 1'b1, 2'd0, 4'd3, 8'hA5);
        cfg(1'b0, 1'b1, 2'd1, 4'd7, 8'h3C);
        cfg(1'b0, 1'b1, 2'd2, 4'd5, 8'h0F);
        cfg(1'b0, 1'b1, 2'd3, 4'd5, 8'hF0);

        for (int i = 0; i < 8; i++) apply(vecs[i]);

        // Held response under backpressure while the matched entry is rewritten.
        @(negedge clk);
        req_valid = 4'b0001; req_key = 16'h0007; default_out = 8'hEE; rsp_ready = 1'b0;
        #1;
        chk("hold_grant_ready", 32'(req_ready), 32'(4'b0001));
        sb.push_back('{2'd0, 1'b1, 8'h3C, 8'h3C});
        @(negedge clk);
        req_valid = 4'hF; cfg_we = 1'b1; cfg_idx = 2'd1; cfg_key = 4'd7; cfg_data = 8'h81;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_valid", 32'(rsp_valid), 32'(1));
            chk("hold_id",    32'(rsp_id),    32'(0));
            chk("hold_data",  32'(rsp_data),  32'(8'h3C));
            chk("hold_hit",   32'(rsp_hit),   32'(1));
            chk("hold_ready", 32'(req_ready), 32'(0));
            @(negedge clk);
        end
        cfg_we = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        wait_rsp();
        apply('{4'b0001, 16'h0007, 8'hEE, 4'b0001, 2'd0, 1'b1, 8'h81, 8'h81});

        // Reset in RESP drops the response and ignores same-cycle cfg/requests.
        @(negedge clk);
        req_valid = 4'b0100; req_key = 16'h0300; rsp_ready = 1'b0;
        #1;
        chk("rstresp_grant", 32'(req_ready), 32'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("rstresp_pending", 32'(rsp_valid), 32'(1));
        rst = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd0; cfg_key = 4'd9; cfg_data = 8'h77;
        req_valid = 4'hF;
        @(negedge clk);
        rst = 1'b0; cfg_we = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        #1;
        chk("rstresp_valid", 32'(rsp_valid), 32'(0));
        chk("rstresp_id",    32'(rsp_id),    32'(0));
        chk("rstresp_data",  32'(rsp_data),  32'(0));
        chk("rstresp_hit",   32'(rsp_hit),   32'(0));
        apply('{4'b1111, 16'h9999, 8'hEE, 4'b0001, 2'd0, 1'b0, 8'hEE, 8'h00});

        cfg(1'b0, 1'b1, 2'd0, 4'd3, 8'hA5);
        apply('{4'b0001, 16'h0003, 8'hEE, 4'b0001, 2'd0, 1'b1, 8'hA5, 8'hA5});
        cfg(1'b1, 1'b0, 2'd0, 4'd0, 8'h00);
        apply('{4'b0001, 16'h0003, 8'hEE, 4'b0001, 2'd0, 1'b0, 8'hEE, 8'h00});
        cfg(1'b1, 1'b1, 2'd1, 4'd6, 8'h42);
        apply('{4'b0001, 16'h0006, 8'hEE, 4'b0001, 2'd0, 1'b1, 8'h42, 8'h42});
        apply('{4'b0001, 16'h0003, 8'hC3, 4'b0001, 2'd0, 1'b0, 8'hC3, 8'h00});

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
